// File: rtl/int_div_arbiter.sv
// int_div_arbiter: shares one int_divider between N requesters, round-robin.
//   A winner's operands are latched and driven to the divider. The arbiter
//   waits SETTLE cycles so the divider can see the new inputs and drop
//   div_rdy, then waits for div_rdy. The quotient goes back to the winner
//   with a one-cycle rsp_vld strobe. Divide-by-zero is answered locally
//   without using the divider.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req[N]             level requests, held until the matching rsp_vld
//   req_dvd/req_dvs    per-requester operands, slice i = requester i
//   gnt[N]             one-hot, requester currently being served
//   rsp_vld[N]         one-cycle response strobe (one-hot or zero)
//   rsp_quo, rsp_err   response quotient, error flag (div-by-zero/timeout)
//   busy               arbiter not idle
//   div_dvd/div_dvs    registered operands to int_divider
//   div_quo/div_rdy    result and ready from int_divider
module int_div_arbiter #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned N       = 4,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_dvd,
  input  logic [N*WIDTH-1:0]   req_dvs,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         rsp_vld,
  output logic [WIDTH-1:0]     rsp_quo,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [WIDTH-1:0]     div_dvd,
  output logic [WIDTH-1:0]     div_dvs,
  input  logic [WIDTH-1:0]     div_quo,
  input  logic                 div_rdy
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  // One counter serves both SETTLE and WAIT; TIMEOUT is the larger bound.
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rsp_quo_q, rsp_quo_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]  div_dvd_q, div_dvd_d;
  logic [WIDTH-1:0]  div_dvs_q, div_dvs_d;

  logic              found;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   idx_w;
  int unsigned       idx;
  logic [WIDTH-1:0]  pick_dvd;
  logic [WIDTH-1:0]  pick_dvs;

  // Round-robin search starting at ptr_q, wrapping upward.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx   = (int'(ptr_q) + i) % N;
      idx_w = IdxW'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  always_comb begin
    pick_dvd = '0;
    pick_dvs = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IdxW'(i) == pick) begin
        pick_dvd = req_dvd[i*WIDTH +: WIDTH];
        pick_dvs = req_dvs[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    rsp_quo_d = rsp_quo_q;
    rsp_err_d = rsp_err_q;
    div_dvd_d = div_dvd_q;
    div_dvs_d = div_dvs_q;
    unique case (state_q)
      StIdle: begin
        // Only start when the divider is quiescent.
        if (found && div_rdy) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          if (pick_dvs == '0) begin
            rsp_quo_d = '1;
            rsp_err_d = 1'b1;
            state_d   = StDone;
          end else begin
            div_dvd_d = pick_dvd;
            div_dvs_d = pick_dvs;
            cnt_d     = '0;
            state_d   = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (div_rdy) begin
          rsp_quo_d = div_quo;
          rsp_err_d = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rsp_quo_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IdxW'(N - 1)) ? '0 : win_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      rsp_quo_q <= '0;
      rsp_err_q <= 1'b0;
      div_dvd_q <= '0;
      div_dvs_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      rsp_quo_q <= rsp_quo_d;
      rsp_err_q <= rsp_err_d;
      div_dvd_q <= div_dvd_d;
      div_dvs_q <= div_dvs_d;
    end
  end

  assign gnt     = gnt_q;
  assign rsp_vld = (state_q == StDone) ? gnt_q : '0;
  assign rsp_quo = rsp_quo_q;
  assign rsp_err = rsp_err_q;
  assign busy    = (state_q != StIdle);
  assign div_dvd = div_dvd_q;
  assign div_dvs = div_dvs_q;

endmodule
